conv_output_packer: RTL and testbench
=====================================

Name: conv_output_packer

Overview:
- Downstream stage of the conv_3_3 accelerator.
- Consumes the accelerator's un-stallable 16-bit output pixel stream (hw_output write_valid/write).
- Packs PACK pixels per word into a first-word-fall-through (FWFT) FIFO and presents the words on a valid/ready stream toward the DMA/host interface.
- Tracks frame position, terminates every frame with a marked last word, and flags drops caused by downstream backpressure.

Parameters:
- DATA_W, 16, pixel width; matches the accelerator output.
- PACK, 4, pixels per output word; power of two, ≥ 2.
- FIFO_DEPTH, 8, output word FIFO entries; power of two, ≥ 2.
- IMG_W, 62, output frame width in pixels.
- IMG_H, 62, output frame height in pixels.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- flush  input  1  synchronous frame restart; same meaning as the accelerator's flush.
- in_valid  input  1  pixel present; driven by hw_output_stencil_op_hcompute_hw_output_stencil_write_valid.
- in_data  input  DATA_W  pixel value.
- out_valid  output  1  word available.
- out_ready  input  1  consumer accepts the word.
- out_data  output  DATA_W*PACK  packed word; lane 0 (first pixel) in bits [DATA_W-1:0].
- out_keep  output  PACK  per-lane valid mask.
- out_last  output  1  word carries the frame's final pixel.
- frame_done  output  1  one-cycle pulse when the final pixel of a frame is captured.
- overflow  output  1  sticky: a completed word was dropped.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset:
  - Clock clk; reset is synchronous, active-low on rst_n.
  - While rst_n=0 at a rising edge: lane counter, col/row counters, pack register and FIFO clear; overflow=0.
  - All outputs read 0 after reset (out_valid, out_data, out_keep, out_last, frame_done, overflow, fifo_count).
  - rst_n has priority over flush.
- No input handshake: a pixel is captured on every edge with in_valid=1. The block never stalls the accelerator.
- Packing:
  - lane counter 0..PACK-1; pixel written into lane `lane`.
  - col counts 0..IMG_W-1 and wraps; row increments on wrap.
  - Lanes continue across row boundaries; no row padding.
- Word completion occurs on the capturing edge when lane==PACK-1 or the pixel is the frame's last (col==IMG_W-1 and row==IMG_H-1).
  - Full word: out_keep all ones.
  - Frame-final partial word: unused lanes zero-filled, out_keep set for filled lanes only (LSB-first), out_last=1.
  - After completion: lane←0; on the last pixel, col←0, row←0 and frame_done pulses on the next cycle.
- FIFO:
  - FWFT; out_data/out_keep/out_last reflect the head entry whenever out_valid=1.
  - Pop on out_valid & out_ready.
  - Latency: completing pixel at edge N, FIFO empty → out_valid=1 after edge N.
- Push while full:
  - With a pop in the same cycle: push accepted, count unchanged.
  - Without a pop: word dropped, overflow←1 (sticky until rst_n). Counters still advance so frame alignment is kept.
- Pop while empty: ignored.
- Output stability: out_data/out_keep/out_last must hold while out_valid=1 & out_ready=0.
- flush=1 at an edge:
  - Clears lane/col/row, pack register and FIFO; a pixel with in_valid in the same cycle is discarded.
  - overflow is not cleared; frame_done is not pulsed.
- Mid-frame rst_n: identical to power-on reset; the partially packed word is lost.

Optional Feature:
- Macro: CONV_OUT_CHECKSUM_EN.
- Defined:
  - Adds port checksum (output, 32 bits).
  - A running sum of captured pixels, zero-extended, mod 2^32, is kept.
  - On the frame's last pixel, checksum←running sum including that pixel, and the running sum resets to 0.
  - Cleared by rst_n and by flush (running sum only; checksum holds last frame's value on flush).
- Undefined: no checksum port and no adder logic; all other behaviour identical.

Test Plan:
- Full frame with defaults: in_valid=1 continuously, in_data ramp 0..3843, out_ready=1.
  - 961 words; first word 0x0003_0002_0001_0000 with keep 0xF.
  - Last word 0x0F03_0F02_0F01_0F00 with out_last=1.
  - frame_done exactly once; overflow=0.
- Partial final word with IMG_W=5, IMG_H=1, pixels 0..4.
  - Words: 0x0003_0002_0001_0000 (keep 0xF, last 0), then 0x0000_0000_0000_0004 (keep 0x1, last 1).
- Backpressure with out_ready=0 and 36 pixels (9 words).
  - fifo_count reaches 8, 9th word dropped, overflow=1.
  - Then out_ready=1 → exactly 8 words drain, 0x0003_0002_0001_0000 through 0x001F_001E_001D_001C; overflow stays 1.
- Full FIFO with push and pop in the same cycle: count stays 8, no drop, overflow=0.
- flush after 6 pixels, then a new ramp from 100.
  - The first completed word was already in the FIFO and is cleared; only the new stream appears.
  - First output word 0x0067_0066_0065_0064; row/col restart, so out_last lands at pixel 3843 of the new frame.
- rst_n=0 mid-frame for 1 cycle with CONV_OUT_CHECKSUM_EN defined.
  - All outputs 0.
  - Next full ramp 0..3843 gives checksum=7,386,246 after frame_done.

Source files
------------

// File: rtl/conv_output_packer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// conv_output_packer
//
// Downstream stage of the conv_3_3 accelerator. Captures the accelerator's
// un-stallable pixel stream, packs PACK pixels per word (lane 0 = first pixel
// in the least significant bits), and queues the words in a first-word-fall-
// through FIFO that feeds a valid/ready stream. Frame position is tracked so
// the final word of every frame is marked with out_last (zero-filled and with
// a partial out_keep when the frame does not fill the word). Words that
// complete while the FIFO is full and nothing is popped are dropped and
// reported through the sticky overflow flag; packing keeps going so frame
// alignment is preserved.
//
// Optional feature: define CONV_OUT_CHECKSUM_EN to add a 32-bit per-frame
// checksum output (sum of the frame's pixels, zero-extended, mod 2^32).
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset (priority over flush)
//   flush        synchronous frame restart; clears packer and FIFO, keeps
//                overflow; a pixel presented in the same cycle is discarded
//   in_valid     pixel present this cycle (no backpressure toward source)
//   in_data      pixel value
//   out_valid    FIFO head word available
//   out_ready    consumer accepts the head word
//   out_data     packed word, lane 0 in [DATA_W-1:0]
//   out_keep     per-lane valid mask, LSB-first
//   out_last     head word carries the frame's final pixel
//   frame_done   one-cycle pulse after the frame's final pixel is captured
//   overflow     sticky: a completed word was dropped
//   fifo_count   FIFO occupancy
//   checksum     (CONV_OUT_CHECKSUM_EN only) checksum of the last frame
// -----------------------------------------------------------------------------
module conv_output_packer #(
  parameter int DATA_W     = 16,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int IMG_W      = 62,
  parameter int IMG_H      = 62
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W*PACK-1:0]        out_data,
  output logic [PACK-1:0]               out_keep,
  output logic                          out_last,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef CONV_OUT_CHECKSUM_EN
  ,
  output logic [31:0]                   checksum
`endif
);

  localparam int WORD_W = DATA_W * PACK;
  localparam int LANE_W = $clog2(PACK);
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;

  localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(PACK - 1);
  localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(IMG_H - 1);
  localparam logic [CW-1:0]     FULL_COUNT = CW'(FIFO_DEPTH);

  // One FIFO entry: the packed word plus its stream sideband.
  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [PACK-1:0]   keep;
    logic              last;
  } word_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [LANE_W-1:0] lane_q,       lane_d;
  logic [COL_W-1:0]  col_q,        col_d;
  logic [ROW_W-1:0]  row_q,        row_d;
  logic [WORD_W-1:0] pack_q,       pack_d;
  logic [AW-1:0]     wr_ptr_q,     wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q,     rd_ptr_d;
  logic [CW-1:0]     count_q,      count_d;
  logic              overflow_q,   overflow_d;
  logic              frame_done_q, frame_done_d;

  word_t             mem_q [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Capture / packing datapath
  // ---------------------------------------------------------------------------
  logic              capture;
  logic              last_pixel;
  logic              word_done;
  logic [WORD_W-1:0] filled_word;
  logic [PACK-1:0]   filled_keep;
  word_t             push_word;

  logic              fifo_full;
  logic              pop;
  logic              push;
  logic              drop;

  // A flushed cycle never captures; reset is handled in the register block.
  assign capture    = in_valid & ~flush;
  assign last_pixel = (col_q == LAST_COL) && (row_q == LAST_ROW);
  assign word_done  = capture && ((lane_q == LAST_LANE) || last_pixel);

  // NOTE: every signal written in an always_comb gets a default at the top of
  // the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    filled_word = pack_q;
    filled_keep = '0;
    for (int l = 0; l < PACK; l++) begin
      // Lanes above the current one are still zero because pack_q is cleared
      // whenever a word completes, which gives the zero-fill for free.
      if (LANE_W'(l) == lane_q) begin
        filled_word[l*DATA_W +: DATA_W] = in_data;
      end
      filled_keep[l] = (LANE_W'(l) <= lane_q);
    end
  end

  assign push_word = '{data: filled_word, keep: filled_keep, last: last_pixel};

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  assign out_valid = (count_q != '0);
  assign fifo_full = (count_q == FULL_COUNT);
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push      = word_done && (!fifo_full || pop);
  assign drop      = word_done && fifo_full && !pop;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    lane_d       = lane_q;
    col_d        = col_q;
    row_d        = row_q;
    pack_d       = pack_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    frame_done_d = 1'b0;

    if (flush) begin
      // Restart the frame; overflow is deliberately kept.
      lane_d   = '0;
      col_d    = '0;
      row_d    = '0;
      pack_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      frame_done_d = capture && last_pixel;

      if (capture) begin
        if (word_done) begin
          lane_d = '0;
          pack_d = '0;
        end else begin
          lane_d = lane_q + 1'b1;
          pack_d = filled_word;
        end

        if (col_q == LAST_COL) begin
          col_d = '0;
          row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end

      // Pointers wrap naturally because FIFO_DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      if (drop) overflow_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      pack_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      col_q        <= col_d;
      row_q        <= row_d;
      pack_q       <= pack_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers and count define which
  // entries are meaningful, and the outputs are gated by out_valid, so a plain
  // RAM-style array is enough.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  word_t head;
  assign head = mem_q[rd_ptr_q];

  // Gating keeps the stream outputs at zero while the FIFO is empty.
  assign out_data   = out_valid ? head.data : '0;
  assign out_keep   = out_valid ? head.keep : '0;
  assign out_last   = out_valid ? head.last : 1'b0;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign fifo_count = count_q;

`ifdef CONV_OUT_CHECKSUM_EN
  // ---------------------------------------------------------------------------
  // Per-frame checksum
  // ---------------------------------------------------------------------------
  logic [31:0] sum_q,      sum_d;
  logic [31:0] checksum_q, checksum_d;
  logic [31:0] sum_plus;

  assign sum_plus = sum_q + 32'(in_data);

  always_comb begin
    sum_d      = sum_q;
    checksum_d = checksum_q;
    if (flush) begin
      // Only the running sum restarts; the last frame's result stays visible.
      sum_d = '0;
    end else if (capture) begin
      if (last_pixel) begin
        checksum_d = sum_plus;
        sum_d      = '0;
      end else begin
        sum_d = sum_plus;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q      <= '0;
      checksum_q <= '0;
    end else begin
      sum_q      <= sum_d;
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_conv_output_packer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_conv_output_packer
//
// Drives conv_output_packer with pixel ramps. A reference packer model builds
// the expected words as pixels are driven and queues them; a monitor pops and
// compares whenever the DUT hands a word over. A second instance with a tiny
// 5x1 frame is checked cycle by cycle from a vector table.
// -----------------------------------------------------------------------------
module tb_conv_output_packer;

  localparam int DATA_W     = 16;
  localparam int PACK       = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int IMG_W      = 62;
  localparam int IMG_H      = 62;
  localparam int WORD_W     = DATA_W * PACK;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;
  localparam int FRAME_PIX  = IMG_W * IMG_H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main instance (default geometry) ----------------
  logic                rst_n;
  logic                flush;
  logic                in_valid;
  logic [DATA_W-1:0]   in_data;
  logic                out_valid;
  logic                out_ready;
  logic [WORD_W-1:0]   out_data;
  logic [PACK-1:0]     out_keep;
  logic                out_last;
  logic                frame_done;
  logic                overflow;
  logic [CW-1:0]       fifo_count;
`ifdef CONV_OUT_CHECKSUM_EN
  logic [31:0]         checksum;
`endif

  conv_output_packer #(
    .DATA_W(DATA_W), .PACK(PACK), .FIFO_DEPTH(FIFO_DEPTH),
    .IMG_W(IMG_W), .IMG_H(IMG_H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .frame_done(frame_done), .overflow(overflow), .fifo_count(fifo_count)
`ifdef CONV_OUT_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  // ---------------- small instance (5x1 frame) ----------------
  logic                s_flush;
  logic                s_in_valid;
  logic [DATA_W-1:0]   s_in_data;
  logic                s_out_valid;
  logic                s_out_ready;
  logic [WORD_W-1:0]   s_out_data;
  logic [PACK-1:0]     s_out_keep;
  logic                s_out_last;
  logic                s_frame_done;
  logic                s_overflow;
  logic [CW-1:0]       s_fifo_count;
`ifdef CONV_OUT_CHECKSUM_EN
  logic [31:0]         s_checksum;
`endif

  conv_output_packer #(
    .DATA_W(DATA_W), .PACK(PACK), .FIFO_DEPTH(FIFO_DEPTH),
    .IMG_W(5), .IMG_H(1)
  ) dut_small (
    .clk(clk), .rst_n(rst_n), .flush(s_flush),
    .in_valid(s_in_valid), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .out_keep(s_out_keep), .out_last(s_out_last),
    .frame_done(s_frame_done), .overflow(s_overflow), .fifo_count(s_fifo_count)
`ifdef CONV_OUT_CHECKSUM_EN
    , .checksum(s_checksum)
`endif
  );

  // ---------------- bookkeeping ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [PACK-1:0]   keep;
    logic              last;
  } exp_word_t;

  exp_word_t sb_q[$];
  bit        sb_enable;

  // Reference packer model state.
  int                m_lane;
  int                m_col;
  int                m_row;
  logic [WORD_W-1:0] m_word;

  task automatic model_reset();
    m_lane = 0;
    m_col  = 0;
    m_row  = 0;
    m_word = '0;
    sb_q.delete();
  endtask

  // Monitor statistics.
  int                mon_words;
  int                done_cnt;
  logic [WORD_W-1:0] first_data;
  logic [WORD_W-1:0] last_data;
  logic              last_flag;
  exp_word_t         mon_e;

  task automatic clear_stats();
    mon_words  = 0;
    done_cnt   = 0;
    first_data = '0;
    last_data  = '0;
    last_flag  = 1'b0;
  endtask

  // Compare every handed-over word against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_pending", 64'(sb_q.size()), 64'd1);
      end else begin
        mon_e = sb_q.pop_front();
        check("word_data", out_data, mon_e.data);
        check("word_keep", 64'(out_keep), 64'(mon_e.keep));
        check("word_last", 64'(out_last), 64'(mon_e.last));
        if (mon_words == 0) first_data = out_data;
        last_data = out_data;
        last_flag = out_last;
        mon_words++;
      end
    end
    if (rst_n && frame_done) done_cnt++;
  end

  // Drive one pixel for one cycle and let the model predict its word.
  task automatic drive_pixel(input logic [DATA_W-1:0] d, input logic rdy);
    exp_word_t e;
    bit        last;
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = rdy;
    m_word[m_lane*DATA_W +: DATA_W] = d;
    last = (m_col == IMG_W - 1) && (m_row == IMG_H - 1);
    if (m_lane == PACK - 1 || last) begin
      e.data = m_word;
      e.keep = '0;
      for (int l = 0; l <= m_lane; l++) e.keep[l] = 1'b1;
      e.last = last;
      if (sb_enable) sb_q.push_back(e);
      m_word = '0;
      m_lane = 0;
    end else begin
      m_lane++;
    end
    if (m_col == IMG_W - 1) begin
      m_col = 0;
      m_row = (m_row == IMG_H - 1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    in_valid  = 1'b0;
    out_ready = rdy;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'hDEAD;
    out_ready = 1'b0;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    model_reset();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"},  64'(out_valid),  64'd0);
    check({tag, "_out_data"},   out_data,        64'd0);
    check({tag, "_out_keep"},   64'(out_keep),   64'd0);
    check({tag, "_out_last"},   64'(out_last),   64'd0);
    check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    check({tag, "_overflow"},   64'(overflow),   64'd0);
    check({tag, "_fifo_count"}, 64'(fifo_count), 64'd0);
`ifdef CONV_OUT_CHECKSUM_EN
    check({tag, "_checksum"},   64'(checksum),   64'd0);
`endif
  endtask

  // Cycle-by-cycle vectors for the 5x1 frame: inputs, then state after the edge.
  typedef struct {
    logic              v;
    logic [DATA_W-1:0] d;
    logic              r;
    logic              ev;
    logic [WORD_W-1:0] ed;
    logic [PACK-1:0]   ek;
    logic              el;
    logic              edone;
    logic [CW-1:0]     ecnt;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b1, 16'd0, 1'b0, 1'b0, 64'h0, 4'h0, 1'b0, 1'b0, 4'd0};
    tbl[1] = '{1'b1, 16'd1, 1'b0, 1'b0, 64'h0, 4'h0, 1'b0, 1'b0, 4'd0};
    tbl[2] = '{1'b1, 16'd2, 1'b0, 1'b0, 64'h0, 4'h0, 1'b0, 1'b0, 4'd0};
    tbl[3] = '{1'b1, 16'd3, 1'b0, 1'b1, 64'h0003_0002_0001_0000, 4'hF, 1'b0, 1'b0, 4'd1};
    tbl[4] = '{1'b1, 16'd4, 1'b0, 1'b1, 64'h0003_0002_0001_0000, 4'hF, 1'b0, 1'b1, 4'd2};
    tbl[5] = '{1'b0, 16'd0, 1'b1, 1'b1, 64'h0000_0000_0000_0004, 4'h1, 1'b1, 1'b0, 4'd1};
    tbl[6] = '{1'b0, 16'd0, 1'b1, 1'b0, 64'h0, 4'h0, 1'b0, 1'b0, 4'd0};
    tbl[7] = '{1'b0, 16'd0, 1'b1, 1'b0, 64'h0, 4'h0, 1'b0, 1'b0, 4'd0};

    rst_n       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    s_flush     = 1'b0;
    s_in_valid  = 1'b0;
    s_in_data   = '0;
    s_out_ready = 1'b0;
    sb_enable   = 1'b1;
    model_reset();
    clear_stats();

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- partial final word on the 5x1 frame ----
    for (int i = 0; i < 8; i++) begin
      s_in_valid  = tbl[i].v;
      s_in_data   = tbl[i].d;
      s_out_ready = tbl[i].r;
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid", i), 64'(s_out_valid),  64'(tbl[i].ev));
      check($sformatf("vec%0d_data", i),  s_out_data,        tbl[i].ed);
      check($sformatf("vec%0d_keep", i),  64'(s_out_keep),   64'(tbl[i].ek));
      check($sformatf("vec%0d_last", i),  64'(s_out_last),   64'(tbl[i].el));
      check($sformatf("vec%0d_done", i),  64'(s_frame_done), 64'(tbl[i].edone));
      check($sformatf("vec%0d_count", i), 64'(s_fifo_count), 64'(tbl[i].ecnt));
    end
    s_in_valid  = 1'b0;
    s_out_ready = 1'b0;

    // ---- full frame, continuous ramp, no backpressure ----
    clear_stats();
    for (int p = 0; p < FRAME_PIX; p++) drive_pixel(16'(p), 1'b1);
    idle(4, 1'b1);
    check("frame_words",      64'(mon_words), 64'd961);
    check("frame_first_word", first_data,     64'h0003_0002_0001_0000);
    check("frame_last_word",  last_data,      64'h0F03_0F02_0F01_0F00);
    check("frame_last_flag",  64'(last_flag), 64'd1);
    check("frame_done_once",  64'(done_cnt),  64'd1);
    check("frame_overflow",   64'(overflow),  64'd0);
    check("frame_sb_drained", 64'(sb_q.size()), 64'd0);

    // ---- full FIFO, push and pop in the same cycle ----
    clear_stats();
    for (int p = 0; p < 32; p++) drive_pixel(16'(p), 1'b0);
    check("pp_count_full", 64'(fifo_count), 64'd8);
    for (int p = 32; p < 35; p++) drive_pixel(16'(p), 1'b0);
    drive_pixel(16'd35, 1'b1);
    check("pp_count_held", 64'(fifo_count), 64'd8);
    check("pp_no_overflow", 64'(overflow),  64'd0);
    idle(12, 1'b1);
    check("pp_words",      64'(mon_words),   64'd9);
    check("pp_sb_drained", 64'(sb_q.size()), 64'd0);
    do_flush();

    // ---- backpressure: ninth word dropped ----
    clear_stats();
    for (int p = 0; p < 32; p++) drive_pixel(16'(p), 1'b0);
    check("bp_count_full",  64'(fifo_count), 64'd8);
    check("bp_no_overflow", 64'(overflow),   64'd0);
    sb_enable = 1'b0;
    for (int p = 32; p < 36; p++) drive_pixel(16'(p), 1'b0);
    sb_enable = 1'b1;
    check("bp_count_after_drop", 64'(fifo_count), 64'd8);
    check("bp_overflow_set",     64'(overflow),   64'd1);
    idle(12, 1'b1);
    check("bp_words",       64'(mon_words),   64'd8);
    check("bp_first_word",  first_data,       64'h0003_0002_0001_0000);
    check("bp_last_word",   last_data,        64'h001F_001E_001D_001C);
    check("bp_overflow_sticky", 64'(overflow), 64'd1);
    check("bp_count_empty", 64'(fifo_count),  64'd0);

    // ---- flush after 6 pixels, then a new frame from 100 ----
    clear_stats();
    for (int p = 0; p < 6; p++) drive_pixel(16'(p), 1'b0);
    check("fl_count_before", 64'(fifo_count), 64'd1);
    do_flush();
    check("fl_count_after",  64'(fifo_count), 64'd0);
    check("fl_valid_after",  64'(out_valid),  64'd0);
    check("fl_overflow_kept", 64'(overflow),  64'd1);
    check("fl_no_done",      64'(frame_done), 64'd0);
    clear_stats();
    for (int p = 0; p < FRAME_PIX; p++) drive_pixel(16'(100 + p), 1'b1);
    idle(4, 1'b1);
    check("fl_words",      64'(mon_words), 64'd961);
    check("fl_first_word", first_data,     64'h0067_0066_0065_0064);
    check("fl_last_word",  last_data,      64'h0F67_0F66_0F65_0F64);
    check("fl_last_flag",  64'(last_flag), 64'd1);
    check("fl_done_once",  64'(done_cnt),  64'd1);
    check("fl_sb_drained", 64'(sb_q.size()), 64'd0);

    // ---- mid-frame reset, then a full frame ----
    for (int p = 0; p < 10; p++) drive_pixel(16'(p), 1'b0);
    check("rs_count_before", 64'(fifo_count), 64'd2);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'd7;
    @(posedge clk); #1;
    check_all_zero("midrst");
    rst_n    = 1'b1;
    in_valid = 1'b0;
    model_reset();
    clear_stats();
    for (int p = 0; p < FRAME_PIX; p++) drive_pixel(16'(p), 1'b1);
    idle(4, 1'b1);
    check("rs_words",     64'(mon_words),  64'd961);
    check("rs_done_once", 64'(done_cnt),   64'd1);
    check("rs_overflow",  64'(overflow),   64'd0);
    check("rs_sb_drained", 64'(sb_q.size()), 64'd0);
`ifdef CONV_OUT_CHECKSUM_EN
    check("rs_checksum",  64'(checksum),   64'd7386246);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
